// File: rtl/srmem_recirc_pkg.sv
// rtl/srmem_recirc_pkg.sv - shared state/tail-select types for the recirculating banked shift-register memory
package srmem_recirc_pkg;

   typedef enum logic [2:0] {
      ST_FILLING = 3'd0,
      ST_ALIGN   = 3'd1,
      ST_MOVING  = 3'd2,
      ST_READING = 3'd3,
      ST_DONE    = 3'd4
   } state_t;

   typedef enum logic [1:0] {
      TAIL_ZERO = 2'd0,
      TAIL_DIN  = 2'd1,
      TAIL_HEAD = 2'd2
   } tail_sel_t;

   // pointer width that never collapses to zero bits
   function automatic int log2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/srmem_recirc_ctrl.sv
// rtl/srmem_recirc_ctrl.sv - combinational next-state, shift-enable and pointer control
module srmem_recirc_ctrl
   import srmem_recirc_pkg::*;
#(
   parameter int NUM_RDPORT = 4,
   parameter int LEN_SRMEM  = 8,
   parameter int NUM_PASS   = 2,
   localparam int MW = log2_min1(NUM_RDPORT),
   localparam int TW = $clog2(LEN_SRMEM + 1),
   localparam int HW = log2_min1(LEN_SRMEM),
   localparam int PW = log2_min1(NUM_PASS)
) (
   input  state_t                state,
   input  logic                  valid_din,
   input  logic                  is_lastdin,
   input  logic                  req_pop,
   input  logic                  req_newdata,
   input  logic                  recirc_en,
   input  logic [MW-1:0]         memptr,
   input  logic [TW-1:0]         tlptr,
   input  logic [HW-1:0]         hdptr,
   input  logic [PW-1:0]         pass_cnt,
   input  logic [TW-1:0]         mv_cnt,
   output state_t                state_nxt,
   output logic [MW-1:0]         memptr_nxt,
   output logic [TW-1:0]         tlptr_nxt,
   output logic [HW-1:0]         hdptr_nxt,
   output logic [PW-1:0]         pass_nxt,
   output logic [TW-1:0]         mv_nxt,
   output logic [NUM_RDPORT-1:0] shift_en,
   output tail_sel_t             tail_sel,
   output logic                  clear,
   output logic                  wrend_nxt,
   output logic                  rdend_nxt,
   output logic                  wrfull,
   output logic                  rdlast,
   output logic                  rdnext
);

   localparam logic [TW-1:0] LEN_T = TW'(LEN_SRMEM);

   logic [TW-1:0] rows;
   logic          row_wrap;
   logic [MW-1:0] memptr_inc;

   always_comb begin
      rows       = tlptr + TW'(memptr != '0);
      wrfull     = (tlptr == LEN_T) && (memptr == '0);
      rdlast     = (state == ST_READING) && (TW'(hdptr) == rows - TW'(1));
      rdnext     = (state == ST_READING) && !rdlast;
      row_wrap   = (memptr == MW'(NUM_RDPORT - 1));
      memptr_inc = row_wrap ? '0 : memptr + MW'(1);
   end

   always_comb begin
      state_nxt  = state;
      memptr_nxt = memptr;
      tlptr_nxt  = tlptr;
      hdptr_nxt  = hdptr;
      pass_nxt   = pass_cnt;
      mv_nxt     = mv_cnt;
      shift_en   = '0;
      tail_sel   = TAIL_ZERO;
      clear      = 1'b0;
      wrend_nxt  = 1'b0;
      rdend_nxt  = 1'b0;
      if (req_newdata) begin
         clear      = 1'b1;
         state_nxt  = ST_FILLING;
         memptr_nxt = '0;
         tlptr_nxt  = '0;
         hdptr_nxt  = '0;
         pass_nxt   = '0;
         mv_nxt     = '0;
      end else begin
         unique case (state)
            ST_FILLING: if (valid_din && !wrfull) begin
               shift_en[memptr] = 1'b1;
               tail_sel         = TAIL_DIN;
               memptr_nxt       = memptr_inc;
               if (row_wrap) tlptr_nxt = tlptr + TW'(1);
               if (is_lastdin) begin
                  wrend_nxt = 1'b1;
                  if (memptr_inc != '0) state_nxt = ST_ALIGN;
                  else if (tlptr_nxt == LEN_T) state_nxt = ST_READING;
                  else begin
                     state_nxt = ST_MOVING;
                     mv_nxt    = LEN_T - tlptr_nxt;
                  end
               end
            end
            ST_ALIGN: begin
               // only the banks that missed the partial last row take a pad entry
               for (int b = 0; b < NUM_RDPORT; b++)
                  shift_en[b] = (MW'(b) >= memptr);
               state_nxt = (rows == LEN_T) ? ST_READING : ST_MOVING;
               mv_nxt    = LEN_T - rows;
            end
            ST_MOVING: begin
               shift_en = '1;
               tail_sel = (pass_cnt != '0) ? TAIL_HEAD : TAIL_ZERO;
               mv_nxt   = mv_cnt - TW'(1);
               if (mv_cnt == TW'(1)) state_nxt = ST_READING;
            end
            ST_READING: if (req_pop) begin
               shift_en  = '1;
               tail_sel  = recirc_en ? TAIL_HEAD : TAIL_ZERO;
               hdptr_nxt = hdptr + HW'(1);
               if (rdlast) begin
                  if (recirc_en && (pass_cnt < PW'(NUM_PASS - 1))) begin
                     pass_nxt  = pass_cnt + PW'(1);
                     hdptr_nxt = '0;
                     state_nxt = (rows == LEN_T) ? ST_READING : ST_MOVING;
                     mv_nxt    = LEN_T - rows;
                  end else begin
                     state_nxt = ST_DONE;
                     rdend_nxt = 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/srmem_recirc.sv
// rtl/srmem_recirc.sv - banked shift-register memory with row alignment and multi-pass recirculation
module srmem_recirc
   import srmem_recirc_pkg::*;
#(
   parameter int NUM_RDPORT = 4,
   parameter int LEN_SRMEM  = 8,
   parameter int DATA_BW    = 8,
   parameter int NUM_PASS   = 2,
   localparam int EW = DATA_BW + 1,
   localparam int PW = log2_min1(NUM_PASS)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     valid_din,
   input  logic [DATA_BW-1:0]       din,
   input  logic                     is_lastdin,
   input  logic                     req_pop,
   input  logic                     req_newdata,
   input  logic                     recirc_en,
   output logic [NUM_RDPORT*EW-1:0] dout_list,
   output logic                     wrfull,
   output logic                     rdvalid,
   output logic                     wrend,
   output logic                     rdend,
   output logic                     rdnext,
   output logic                     rdlast,
   output logic [PW-1:0]            pass_cnt
);

   localparam int MW = log2_min1(NUM_RDPORT);
   localparam int TW = $clog2(LEN_SRMEM + 1);
   localparam int HW = log2_min1(LEN_SRMEM);

   state_t                state, state_nxt;
   logic [MW-1:0]         memptr, memptr_nxt;
   logic [TW-1:0]         tlptr, tlptr_nxt;
   logic [HW-1:0]         hdptr, hdptr_nxt;
   logic [PW-1:0]         pass_nxt;
   logic [TW-1:0]         mv_cnt, mv_nxt;
   logic [NUM_RDPORT-1:0] shift_en;
   tail_sel_t             tail_sel;
   logic                  clear, wrend_nxt, rdend_nxt;

   // index 0 is the head of each bank; entries enter at LEN_SRMEM-1
   logic [EW-1:0] mem    [NUM_RDPORT][LEN_SRMEM];
   logic [EW-1:0] tail_d [NUM_RDPORT];

   srmem_recirc_ctrl #(
      .NUM_RDPORT (NUM_RDPORT),
      .LEN_SRMEM  (LEN_SRMEM),
      .NUM_PASS   (NUM_PASS)
   ) u_ctrl (
      .state       (state),
      .valid_din   (valid_din),
      .is_lastdin  (is_lastdin),
      .req_pop     (req_pop),
      .req_newdata (req_newdata),
      .recirc_en   (recirc_en),
      .memptr      (memptr),
      .tlptr       (tlptr),
      .hdptr       (hdptr),
      .pass_cnt    (pass_cnt),
      .mv_cnt      (mv_cnt),
      .state_nxt   (state_nxt),
      .memptr_nxt  (memptr_nxt),
      .tlptr_nxt   (tlptr_nxt),
      .hdptr_nxt   (hdptr_nxt),
      .pass_nxt    (pass_nxt),
      .mv_nxt      (mv_nxt),
      .shift_en    (shift_en),
      .tail_sel    (tail_sel),
      .clear       (clear),
      .wrend_nxt   (wrend_nxt),
      .rdend_nxt   (rdend_nxt),
      .wrfull      (wrfull),
      .rdlast      (rdlast),
      .rdnext      (rdnext)
   );

   always_comb begin
      dout_list = '0;
      for (int b = 0; b < NUM_RDPORT; b++) begin
         unique case (tail_sel)
            TAIL_DIN:  tail_d[b] = {1'b1, din};
            TAIL_HEAD: tail_d[b] = mem[b][0];
            default:   tail_d[b] = '0;
         endcase
         dout_list[b*EW +: EW] = mem[b][0];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= ST_FILLING;
         memptr   <= '0;
         tlptr    <= '0;
         hdptr    <= '0;
         pass_cnt <= '0;
         mv_cnt   <= '0;
         wrend    <= 1'b0;
         rdend    <= 1'b0;
         for (int b = 0; b < NUM_RDPORT; b++)
            for (int i = 0; i < LEN_SRMEM; i++)
               mem[b][i] <= '0;
      end else begin
         state    <= state_nxt;
         memptr   <= memptr_nxt;
         tlptr    <= tlptr_nxt;
         hdptr    <= hdptr_nxt;
         pass_cnt <= pass_nxt;
         mv_cnt   <= mv_nxt;
         wrend    <= wrend_nxt;
         rdend    <= rdend_nxt;
         for (int b = 0; b < NUM_RDPORT; b++) begin
            if (clear) begin
               for (int i = 0; i < LEN_SRMEM; i++)
                  mem[b][i] <= '0;
            end else if (shift_en[b]) begin
               for (int i = 0; i < LEN_SRMEM - 1; i++)
                  mem[b][i] <= mem[b][i+1];
               mem[b][LEN_SRMEM-1] <= tail_d[b];
            end
         end
      end
   end

   assign rdvalid = (state == ST_READING);

endmodule

// File: tb/tb_srmem_recirc.sv
// tb/tb_srmem_recirc.sv - directed and randomized bench against a row-level reference model
module tb_srmem_recirc;

   localparam int N  = 4;
   localparam int L  = 8;
   localparam int DW = 8;
   localparam int NP = 2;
   localparam int EW = DW + 1;

   localparam int P_FILL = 0;
   localparam int P_WAIT = 1;
   localparam int P_READ = 2;
   localparam int P_DONE = 3;

   logic            clk = 1'b0;
   logic            rst, valid_din, is_lastdin, req_pop, req_newdata, recirc_en;
   logic [DW-1:0]   din;
   logic [N*EW-1:0] dout_list;
   logic            wrfull, rdvalid, wrend, rdend, rdnext, rdlast;
   logic [0:0]      pass_cnt;

   int n_vec = 0;
   int n_bad = 0;

   // reference model: written items, readout phase, head row, pass and per-row survival
   logic [DW-1:0] items [N*L];
   int            n, phase, wait_c, head, pass;
   bit            alive [L];
   bit            wrend_e, rdend_e;

   always #5 clk = ~clk;

   srmem_recirc #(.NUM_RDPORT(N), .LEN_SRMEM(L), .DATA_BW(DW), .NUM_PASS(NP)) dut (
      .clk         (clk),
      .rst         (rst),
      .valid_din   (valid_din),
      .din         (din),
      .is_lastdin  (is_lastdin),
      .req_pop     (req_pop),
      .req_newdata (req_newdata),
      .recirc_en   (recirc_en),
      .dout_list   (dout_list),
      .wrfull      (wrfull),
      .rdvalid     (rdvalid),
      .wrend       (wrend),
      .rdend       (rdend),
      .rdnext      (rdnext),
      .rdlast      (rdlast),
      .pass_cnt    (pass_cnt)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int rows_of(input int cnt);
      return (cnt + N - 1) / N;
   endfunction

   function automatic logic [N*EW-1:0] exp_dout();
      logic [N*EW-1:0] v;
      v = '0;
      for (int b = 0; b < N; b++) begin
         int idx;
         int in_bank;
         if (phase == P_READ) begin
            idx = head * N + b;
            if (idx < n && alive[head]) v[b*EW +: EW] = {1'b1, items[idx]};
         end else begin
            in_bank = n / N + ((b < n % N) ? 1 : 0);
            if (in_bank == L) v[b*EW +: EW] = {1'b1, items[b]};
         end
      end
      return v;
   endfunction

   task automatic model_clear();
      n = 0; phase = P_FILL; wait_c = 0; head = 0; pass = 0;
      for (int i = 0; i < L; i++) alive[i] = 1'b1;
   endtask

   task automatic model_step(input bit r, input bit v, input logic [DW-1:0] d, input bit l,
                             input bit p, input bit nd, input bit rc);
      wrend_e = 1'b0;
      rdend_e = 1'b0;
      if (!r || nd) model_clear();
      else begin
         case (phase)
            P_FILL: if (v && n < N * L) begin
               items[n] = d;
               n++;
               if (l) begin
                  wrend_e = 1'b1;
                  wait_c  = ((n % N) != 0 ? 1 : 0) + L - rows_of(n);
                  phase   = (wait_c == 0) ? P_READ : P_WAIT;
               end
            end
            P_WAIT: begin
               wait_c--;
               if (wait_c == 0) phase = P_READ;
            end
            P_READ: if (p) begin
               if (!rc) alive[head] = 1'b0;
               if (head == rows_of(n) - 1) begin
                  if (rc && pass < NP - 1) begin
                     pass++;
                     head   = 0;
                     wait_c = L - rows_of(n);
                     phase  = (wait_c == 0) ? P_READ : P_WAIT;
                  end else begin
                     phase   = P_DONE;
                     rdend_e = 1'b1;
                  end
               end else head++;
            end
            default: ;
         endcase
      end
   endtask

   task automatic check_outputs();
      bit last_e;
      last_e = (phase == P_READ) && (head == rows_of(n) - 1);
      chk("rdvalid", 64'(rdvalid), 64'(phase == P_READ));
      chk("rdlast", 64'(rdlast), 64'(last_e));
      chk("rdnext", 64'(rdnext), 64'((phase == P_READ) && !last_e));
      chk("wrfull", 64'(wrfull), 64'(n == N * L));
      chk("wrend", 64'(wrend), 64'(wrend_e));
      chk("rdend", 64'(rdend), 64'(rdend_e));
      chk("pass_cnt", 64'(pass_cnt), 64'(pass));
      if (phase == P_READ || phase == P_FILL)
         chk("dout_list", 64'(dout_list), 64'(exp_dout()));
   endtask

   task automatic cyc(input bit r, input bit v, input logic [DW-1:0] d, input bit l,
                      input bit p, input bit nd, input bit rc);
      @(negedge clk);
      check_outputs();
      rst = r; valid_din = v; din = d; is_lastdin = l;
      req_pop = p; req_newdata = nd; recirc_en = rc;
      model_step(r, v, d, l, p, nd, rc);
   endtask

   task automatic idle(input int k);
      for (int i = 0; i < k; i++) cyc(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic write_seq(input int cnt, input int base, input bit with_last);
      for (int i = 0; i < cnt; i++)
         cyc(1'b1, 1'b1, DW'(base + i), with_last && (i == cnt - 1), 1'b0, 1'b0, 1'b0);
   endtask

   task automatic pops(input int k, input bit rc);
      for (int i = 0; i < k; i++) cyc(1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b0, rc);
   endtask

   task automatic newdata();
      cyc(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
   endtask

   initial begin
      int  len, w, r;
      bit  v;
      rst = 1'b0; valid_din = 1'b0; din = '0; is_lastdin = 1'b0;
      req_pop = 1'b0; req_newdata = 1'b0; recirc_en = 1'b0;
      wrend_e = 1'b0; rdend_e = 1'b0;
      model_clear();
      cyc(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);

      // full batch: no alignment or moving, readable straight away
      write_seq(32, 0, 1'b1);
      idle(2);
      pops(8, 1'b0);
      idle(2);

      // partial batch with two recirculated passes
      newdata();
      write_seq(10, 0, 1'b1);
      idle(7);
      pops(3, 1'b1);
      idle(6);
      pops(3, 1'b1);
      idle(2);

      // discard mid-read, then a single-row batch
      newdata();
      write_seq(10, 0, 1'b1);
      idle(7);
      pops(1, 1'b0);
      newdata();
      write_seq(4, 0, 1'b1);
      idle(8);
      pops(1, 1'b0);
      idle(1);

      // reset during moving, with a write attempted under reset
      newdata();
      write_seq(10, 0, 1'b1);
      idle(3);
      cyc(1'b0, 1'b1, 8'hAA, 1'b1, 1'b1, 1'b0, 1'b1);
      idle(1);

      // ignored requests: pop while filling, writes while full, pop racing newdata
      write_seq(5, 40, 1'b0);
      cyc(1'b1, 1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b1);
      write_seq(27, 45, 1'b0);
      cyc(1'b1, 1'b1, 8'h55, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 8'h66, 1'b0, 1'b1, 1'b0, 1'b0);
      newdata();
      write_seq(8, 7, 1'b1);
      idle(7);
      cyc(1'b1, 1'b1, 8'h77, 1'b1, 1'b1, 1'b1, 1'b1);
      idle(1);

      for (int t = 0; t < 30; t++) begin
         len = $urandom_range(1, N * L);
         w   = 0;
         newdata();
         for (int g = 0; g < 400 && w < len; g++) begin
            v = ($urandom_range(0, 3) != 0);
            cyc(1'b1, v, DW'($urandom), v ? (w == len - 1) : ($urandom_range(0, 1) == 1),
                ($urandom_range(0, 1) == 1), 1'b0, 1'b1);
            if (v) w++;
         end
         for (int c = 0; c < 150 && phase != P_DONE; c++) begin
            r = $urandom_range(0, 199);
            cyc(r != 0, 1'b0, '0, 1'b0, ($urandom_range(0, 1) == 1), r == 1,
                ($urandom_range(0, 3) != 0));
         end
      end

      @(negedge clk);
      check_outputs();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
